ddr_write_arbiter: RTL and testbench
====================================

// Module: ddr_write_arbiter
// PURPOSE
//  Shares the single DDR write path (address FIFO af_*, write-data FIFO wdf_*) between two pixel
//  writers: requester 0 = line engine, requester 1 = frame fill/clear engine or CPU pixel path.
//  Keeps each write transaction atomic: one address plus BURST_BEATS data beats from one owner.
//  Alternates owners round-robin at transaction boundaries. Sits between the writers and the DDR
//  controller FIFOs.
// PARAMETERS
//  ADDR_W       31  width of af_addr_din (all address ports)
//  BURST_BEATS  2   wdf beats per transaction (first beat travels with the address); legal >= 2
// PORTS
//  clk               in   1       clock
//  rst               in   1       reset; synchronous, active-high
//  rN_af_addr_din    in   ADDR_W  requester N address (N=0,1; all rN_ ports exist per requester)
//  rN_af_wr_en       in   1       requester N address write / transaction request
//  rN_wdf_din        in   128     requester N write data
//  rN_wdf_mask_din   in   16      requester N byte mask (1 = byte not written)
//  rN_wdf_wr_en      in   1       requester N data write
//  rN_af_full        out  1       requester N address FIFO full (1 whenever not allowed to issue)
//  rN_wdf_full       out  1       requester N data FIFO full (1 whenever not allowed to issue)
//  af_full           in   1       DDR address FIFO full
//  wdf_full          in   1       DDR write-data FIFO full
//  af_addr_din       out  ADDR_W  muxed address to DDR
//  af_wr_en          out  1       address write, pulsed only on accepted beat 1
//  wdf_din           out  128     muxed data to DDR
//  wdf_mask_din      out  16      muxed mask; 16'hFFFF when no owner
//  wdf_wr_en         out  1       data write, pulsed only on accepted beats
//  owner             out  1       current/last granted requester
//  busy              out  1       1 in BEAT1/BEAT_N
// BEHAVIOUR
//  Reset values: state=IDLE, owner=0, last_owner=1 (r0 wins first), beat count=0.
//  Reset outputs: af_wr_en=0, wdf_wr_en=0, busy=0, rN_*_full=1, wdf_mask_din=16'hFFFF,
//  af_addr_din=0, wdf_din=0.
//  Full outputs and write enables depend only on registered state and the DDR fulls. There is no
//  combinational path from rN_* requests to rN_*_full.
//  IDLE: nothing forwarded; both rN fulls = 1.
//   - If any rN_af_wr_en is high, grant it. If both are high, grant N != last_owner.
//   - Latch owner; next state = BEAT1 (one-cycle grant latency).
//  BEAT1: address/data/mask muxed from owner.
//   - rO_af_full = af_full; rO_wdf_full = wdf_full. Non-owner fulls = 1.
//   - accept = rO_af_wr_en & rO_wdf_wr_en & !af_full & !wdf_full.
//   - On accept: af_wr_en = wdf_wr_en = 1 in the same cycle; next state = BEAT_N, count = 1.
//   - No accept while rO_af_wr_en is high: hold in BEAT1, outputs 0.
//   - rO_af_wr_en low: request withdrawn; go to IDLE, last_owner unchanged.
//  BEAT_N: owner af_full forced 1; af_wr_en = 0; rO_wdf_full = wdf_full.
//   - wdf_wr_en = rO_wdf_wr_en & !wdf_full.
//   - Each accepted beat increments count.
//  Final beat accepted (count == BURST_BEATS-1):
//   - last_owner <= owner.
//   - Other requester's af_wr_en high: BEAT1 with the other requester, no IDLE bubble.
//   - Else owner's af_wr_en high: BEAT1 with the same owner.
//   - Else: IDLE.
//  Downstream full mid-burst: hold; grant never changes until the final beat.
//  Reset mid-transaction: the partial burst is abandoned and the block returns to IDLE next cycle.
//  Upstream writers share rst, so no orphaned beats remain.
// TESTING
//  1. Only r0 issues 2 transactions, fulls=0
//     -> r0 granted the cycle after request; each transaction = 1 af + 2 wdf writes;
//        back-to-back with no idle cycle.
//  2. r0 and r1 both request continuously
//     -> grants alternate r0,r1,r0,r1; addresses/data never interleave inside a transaction.
//  3. wdf_full=1 for 3 cycles during BEAT_N of r1
//     -> wdf_wr_en=0 those cycles, r1_wdf_full=1, r0 still blocked; beat 2 completes after release.
//  4. af_full=1 at BEAT1 with wdf_full=0
//     -> af_wr_en=0 and wdf_wr_en=0 (beat 1 not split from its address); proceeds when af_full drops.
//  5. r1 drops r1_af_wr_en in BEAT1
//     -> IDLE next cycle, last_owner unchanged; r0 request then granted.
//  6. rst during BEAT_N
//     -> next cycle all enables 0, both rN fulls 1, wdf_mask_din=16'hFFFF; first grant after reset goes to r0.

Source files
------------

// File: rtl/ddr_write_arbiter.sv
// ddr_write_arbiter
//
// Purpose:
//    Lets two pixel writers share one DDR write path. The path is an address FIFO (af_*) and a
//    write-data FIFO (wdf_*). Requester 0 is the line engine. Requester 1 is the fill/clear engine
//    or the CPU pixel path.
//    Each write transaction is one address plus BURST_BEATS data beats. The first data beat travels
//    with the address. A transaction always comes from a single owner and is never interleaved with
//    the other requester. Ownership alternates round-robin at transaction boundaries.
//
// Ports:
//    clk, rst                      clock; synchronous active-high reset
//    rN_af_addr_din / rN_af_wr_en  requester N address and transaction request (N = 0, 1)
//    rN_wdf_din / rN_wdf_mask_din  requester N write data and byte mask (1 = byte not written)
//    rN_wdf_wr_en                  requester N data write
//    rN_af_full / rN_wdf_full      back-pressure to requester N; 1 whenever it may not issue
//    af_full / wdf_full            DDR controller FIFO fulls
//    af_addr_din / af_wr_en        muxed address; the write strobe pulses only with data beat 1
//    wdf_din / wdf_mask_din        muxed data and mask; the mask is all ones when nobody owns the path
//    wdf_wr_en                     data write strobe; pulses once per accepted beat
//    owner                         current or most recently granted requester
//    busy                          a transaction is in progress

module ddr_write_arbiter #(
   parameter int ADDR_W      = 31,
   parameter int BURST_BEATS = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] r0_af_addr_din,
   input  logic              r0_af_wr_en,
   input  logic [127:0]      r0_wdf_din,
   input  logic [15:0]       r0_wdf_mask_din,
   input  logic              r0_wdf_wr_en,
   output logic              r0_af_full,
   output logic              r0_wdf_full,
   input  logic [ADDR_W-1:0] r1_af_addr_din,
   input  logic              r1_af_wr_en,
   input  logic [127:0]      r1_wdf_din,
   input  logic [15:0]       r1_wdf_mask_din,
   input  logic              r1_wdf_wr_en,
   output logic              r1_af_full,
   output logic              r1_wdf_full,
   input  logic              af_full,
   input  logic              wdf_full,
   output logic [ADDR_W-1:0] af_addr_din,
   output logic              af_wr_en,
   output logic [127:0]      wdf_din,
   output logic [15:0]       wdf_mask_din,
   output logic              wdf_wr_en,
   output logic              owner,
   output logic              busy
);

   localparam int CNT_W = $clog2(BURST_BEATS) + 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_BEATS - 1);

   typedef enum logic [1:0] {
      IDLE,
      BEAT1,
      BEAT_N
   } state_t;

   state_t           state, state_next;
   logic             owner_next;
   logic             last_owner, last_owner_next;
   logic [CNT_W-1:0] count, count_next;

   logic             own_af_req, own_wdf_req, other_af_req;
   logic             own_af_full, own_wdf_full;
   logic             forward;

   // Requests seen from the point of view of the current owner
   assign own_af_req   = owner ? r1_af_wr_en  : r0_af_wr_en;
   assign own_wdf_req  = owner ? r1_wdf_wr_en : r0_wdf_wr_en;
   assign other_af_req = owner ? r0_af_wr_en  : r1_af_wr_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_owner <= 1'b1;
         count      <= '0;
      end else begin
         state      <= state_next;
         owner      <= owner_next;
         last_owner <= last_owner_next;
         count      <= count_next;
      end
   end

   // Beat 1 is accepted only when the address and the data can both enter their DDR FIFOs.
   // This keeps the address from being split from its first beat.
   // Once a burst starts, the owner's address path is closed until the final beat.
   // At that point the other requester is offered the path first, with no idle bubble.
   always_comb begin
      state_next      = state;
      owner_next      = owner;
      last_owner_next = last_owner;
      count_next      = count;
      af_wr_en        = 1'b0;
      wdf_wr_en       = 1'b0;
      own_af_full     = 1'b1;
      own_wdf_full    = 1'b1;
      forward         = 1'b0;

      case (state)
         IDLE: begin
            if (r0_af_wr_en || r1_af_wr_en) begin
               state_next = BEAT1;
               if (r0_af_wr_en && r1_af_wr_en) begin
                  owner_next = ~last_owner;
               end else begin
                  owner_next = r1_af_wr_en;
               end
            end
         end

         BEAT1: begin
            forward      = 1'b1;
            own_af_full  = af_full;
            own_wdf_full = wdf_full;
            if (own_af_req && own_wdf_req && !af_full && !wdf_full) begin
               af_wr_en   = 1'b1;
               wdf_wr_en  = 1'b1;
               count_next = CNT_W'(1);
               state_next = BEAT_N;
            end else if (!own_af_req) begin
               state_next = IDLE;
            end
         end

         BEAT_N: begin
            forward      = 1'b1;
            own_wdf_full = wdf_full;
            if (own_wdf_req && !wdf_full) begin
               wdf_wr_en = 1'b1;
               if (count == LAST_BEAT) begin
                  count_next      = '0;
                  last_owner_next = owner;
                  if (other_af_req) begin
                     owner_next = ~owner;
                     state_next = BEAT1;
                  end else if (own_af_req) begin
                     state_next = BEAT1;
                  end else begin
                     state_next = IDLE;
                  end
               end else begin
                  count_next = count + CNT_W'(1);
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // The back-pressure outputs depend only on state, owner and the DDR fulls,
   // never on the incoming requests.
   assign r0_af_full  = owner ? 1'b1 : own_af_full;
   assign r0_wdf_full = owner ? 1'b1 : own_wdf_full;
   assign r1_af_full  = owner ? own_af_full  : 1'b1;
   assign r1_wdf_full = owner ? own_wdf_full : 1'b1;

   assign af_addr_din  = forward ? (owner ? r1_af_addr_din  : r0_af_addr_din)  : '0;
   assign wdf_din      = forward ? (owner ? r1_wdf_din      : r0_wdf_din)      : '0;
   assign wdf_mask_din = forward ? (owner ? r1_wdf_mask_din : r0_wdf_mask_din) : 16'hFFFF;
   assign busy         = (state != IDLE);

endmodule

// File: tb/tb_ddr_write_arbiter.sv
// tb_ddr_write_arbiter
//
// Purpose:
//    Drives both requester ports from simple writer models. Each writer owns a list of
//    transactions with random addresses, data and masks. The expected DDR-side traffic and the
//    expected back-pressure are predicted from a transaction-level account of the arbitration
//    rules. That account tracks whether a transaction is open, whether its address has gone,
//    how many beats have gone, the owner, and who went last.
//    The writers advance on the predicted acceptances, so the stimulus never depends on the DUT.
//
// Ports:
//    none (self-contained bench)

module tb_ddr_write_arbiter;

   localparam int ADDR_W = 31;
   localparam int BB     = 2;
   localparam int NTX    = 512;

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] r0_af_addr_din, r1_af_addr_din;
   logic              r0_af_wr_en, r1_af_wr_en;
   logic [127:0]      r0_wdf_din, r1_wdf_din;
   logic [15:0]       r0_wdf_mask_din, r1_wdf_mask_din;
   logic              r0_wdf_wr_en, r1_wdf_wr_en;
   logic              r0_af_full, r0_wdf_full, r1_af_full, r1_wdf_full;
   logic              af_full, wdf_full;
   logic [ADDR_W-1:0] af_addr_din;
   logic              af_wr_en;
   logic [127:0]      wdf_din;
   logic [15:0]       wdf_mask_din;
   logic              wdf_wr_en;
   logic              owner;
   logic              busy;

   always #5 clk = ~clk;

   ddr_write_arbiter #(.ADDR_W(ADDR_W), .BURST_BEATS(BB)) dut (
      .clk(clk), .rst(rst),
      .r0_af_addr_din(r0_af_addr_din), .r0_af_wr_en(r0_af_wr_en),
      .r0_wdf_din(r0_wdf_din), .r0_wdf_mask_din(r0_wdf_mask_din), .r0_wdf_wr_en(r0_wdf_wr_en),
      .r0_af_full(r0_af_full), .r0_wdf_full(r0_wdf_full),
      .r1_af_addr_din(r1_af_addr_din), .r1_af_wr_en(r1_af_wr_en),
      .r1_wdf_din(r1_wdf_din), .r1_wdf_mask_din(r1_wdf_mask_din), .r1_wdf_wr_en(r1_wdf_wr_en),
      .r1_af_full(r1_af_full), .r1_wdf_full(r1_wdf_full),
      .af_full(af_full), .wdf_full(wdf_full),
      .af_addr_din(af_addr_din), .af_wr_en(af_wr_en),
      .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en),
      .owner(owner), .busy(busy)
   );

   int check_count = 0;
   int fail_count  = 0;

   // Writer transaction stores and progress
   logic [ADDR_W-1:0] addr_mem [2][NTX];
   logic [127:0]      data_mem [2][NTX][BB];
   logic [15:0]       mask_mem [2][NTX][BB];
   int                cur [2];
   int                tot [2];
   int                beat [2];

   // Stimulus knobs
   bit en [2];
   bit af_full_k, wdf_full_k, rst_k;

   // Values currently driven by each writer
   logic              req_af [2];
   logic              req_wdf [2];
   logic [ADDR_W-1:0] drv_addr [2];
   logic [127:0]      drv_data [2];
   logic [15:0]       drv_mask [2];

   assign r0_af_wr_en     = req_af[0];
   assign r1_af_wr_en     = req_af[1];
   assign r0_wdf_wr_en    = req_wdf[0];
   assign r1_wdf_wr_en    = req_wdf[1];
   assign r0_af_addr_din  = drv_addr[0];
   assign r1_af_addr_din  = drv_addr[1];
   assign r0_wdf_din      = drv_data[0];
   assign r1_wdf_din      = drv_data[1];
   assign r0_wdf_mask_din = drv_mask[0];
   assign r1_wdf_mask_din = drv_mask[1];

   // Arbitration account
   bit m_busy, m_addr_done;
   int m_own, m_last, m_beats;
   bit idle_const_check;

   task automatic checkOutput(input string tag, input logic [159:0] got, input logic [159:0] exp);
      check_count++;
      if (got !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic queueTxn(input int r, input int n);
      for (int k = 0; k < n; k++) begin
         if (tot[r] < NTX) begin
            addr_mem[r][tot[r]] = {r[0], 30'($urandom)};
            for (int b = 0; b < BB; b++) begin
               data_mem[r][tot[r]][b] = {r[0], 15'(tot[r]), 8'(b),
                                         104'({$urandom, $urandom, $urandom, $urandom})};
               mask_mem[r][tot[r]][b] = 16'($urandom);
            end
            tot[r]++;
         end
      end
   endtask

   // A writer asks for a new address when it is between transactions. Mid-burst it may
   // already ask for the address of its next transaction. It keeps presenting data until
   // the current transaction is finished.
   task automatic applyStimulus();
      for (int r = 0; r < 2; r++) begin
         bit pend, next_pend;
         pend      = cur[r] < tot[r];
         next_pend = (cur[r] + 1) < tot[r];
         req_af[r]  = en[r] && ((beat[r] == 0 && pend) || (beat[r] > 0 && next_pend));
         req_wdf[r] = pend && (en[r] || beat[r] > 0);
         if (req_af[r]) drv_addr[r] = (beat[r] == 0) ? addr_mem[r][cur[r]] : addr_mem[r][cur[r] + 1];
         else drv_addr[r] = '0;
         drv_data[r] = pend ? data_mem[r][cur[r]][beat[r]] : '0;
         drv_mask[r] = pend ? mask_mem[r][cur[r]][beat[r]] : 16'h0;
      end
      rst      = rst_k;
      af_full  = af_full_k;
      wdf_full = wdf_full_k;
   endtask

   task automatic stepCycle();
      int         o;
      logic       exp_af, exp_wdf;
      logic [1:0] exp_af_full, exp_wdf_full;
      applyStimulus();
      @(negedge clk);
      o            = m_own;
      exp_af       = 1'b0;
      exp_wdf      = 1'b0;
      exp_af_full  = 2'b11;
      exp_wdf_full = 2'b11;
      if (m_busy && !m_addr_done) begin
         exp_af_full[o]  = af_full_k;
         exp_wdf_full[o] = wdf_full_k;
         exp_af  = req_af[o] && req_wdf[o] && !af_full_k && !wdf_full_k;
         exp_wdf = exp_af;
      end else if (m_busy) begin
         exp_wdf_full[o] = wdf_full_k;
         exp_wdf = req_wdf[o] && !wdf_full_k;
      end
      checkOutput("busy", 160'(busy), 160'(m_busy));
      checkOutput("owner", 160'(owner), 160'(o));
      checkOutput("af_wr_en", 160'(af_wr_en), 160'(exp_af));
      checkOutput("wdf_wr_en", 160'(wdf_wr_en), 160'(exp_wdf));
      checkOutput("rN_af_full", 160'({r1_af_full, r0_af_full}), 160'(exp_af_full));
      checkOutput("rN_wdf_full", 160'({r1_wdf_full, r0_wdf_full}), 160'(exp_wdf_full));
      if (exp_af) checkOutput("af_addr", 160'(af_addr_din), 160'(drv_addr[o]));
      if (exp_wdf) checkOutput("wdf_beat", 160'({wdf_mask_din, wdf_din}), 160'({drv_mask[o], drv_data[o]}));
      if (!m_busy) checkOutput("idle_mask", 160'(wdf_mask_din), 160'(16'hFFFF));
      if (idle_const_check) begin
         idle_const_check = 1'b0;
         checkOutput("rst_enables", 160'({af_wr_en, wdf_wr_en, busy}), 160'(3'b000));
         checkOutput("rst_fulls", 160'({r1_af_full, r1_wdf_full, r0_af_full, r0_wdf_full}), 160'(4'b1111));
         checkOutput("rst_owner", 160'(owner), 160'(1'b0));
         checkOutput("rst_datapath", 160'({wdf_mask_din, af_addr_din, wdf_din}),
                     160'({16'hFFFF, {ADDR_W{1'b0}}, 128'h0}));
      end
      @(posedge clk);
      if (rst_k) begin
         m_busy = 0; m_addr_done = 0; m_own = 0; m_last = 1; m_beats = 0;
         beat[0] = 0; beat[1] = 0;
         idle_const_check = 1'b1;
      end else if (!m_busy) begin
         if (req_af[0] || req_af[1]) begin
            m_own       = (req_af[0] && req_af[1]) ? 1 - m_last : (req_af[1] ? 1 : 0);
            m_busy      = 1;
            m_addr_done = 0;
         end
      end else if (!m_addr_done) begin
         if (exp_af) begin
            m_addr_done = 1;
            m_beats     = 1;
            beat[o]     = 1;
         end else if (!req_af[o]) begin
            m_busy = 0;
         end
      end else if (exp_wdf) begin
         m_beats++;
         beat[o]++;
         if (m_beats == BB) begin
            beat[o] = 0;
            cur[o]++;
            m_last  = o;
            m_beats = 0;
            if (req_af[1 - o]) begin
               m_own = 1 - o;
               m_addr_done = 0;
            end else if (req_af[o]) begin
               m_addr_done = 0;
            end else begin
               m_busy = 0;
            end
         end
      end
      #1;
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) stepCycle();
   endtask

   // Steps until a transaction of the chosen owner (-1 = either) reaches the wanted phase
   task automatic runUntil(input int who, input bit data_phase, input string tag);
      bit reached;
      reached = 0;
      for (int i = 0; i < 40 && !reached; i++) begin
         if (m_busy && (m_addr_done == data_phase) && (who < 0 || m_own == who)) reached = 1;
         else stepCycle();
      end
      checkOutput(tag, 160'(reached), 160'(1'b1));
   endtask

   initial begin
      cur[0] = 0; cur[1] = 0; tot[0] = 0; tot[1] = 0; beat[0] = 0; beat[1] = 0;
      en[0] = 0; en[1] = 0; af_full_k = 0; wdf_full_k = 0; rst_k = 1;
      m_busy = 0; m_addr_done = 0; m_own = 0; m_last = 1; m_beats = 0;
      idle_const_check = 1'b0;
      applyStimulus();
      @(posedge clk);
      #1;
      stepCycle();
      rst_k = 0;

      $display("[TB] r0 alone, two back-to-back transactions");
      queueTxn(0, 2);
      en[0] = 1;
      runCycles(8);

      $display("[TB] both requesters continuously");
      queueTxn(0, 4);
      queueTxn(1, 4);
      en[1] = 1;
      runCycles(20);

      $display("[TB] wdf_full during r1 data beats");
      queueTxn(0, 2);
      queueTxn(1, 2);
      runUntil(1, 1, "reach_r1_data");
      wdf_full_k = 1;
      runCycles(3);
      wdf_full_k = 0;
      runCycles(12);

      $display("[TB] af_full at r0 address beat");
      en[1] = 0;
      queueTxn(0, 1);
      af_full_k = 1;
      runUntil(0, 0, "reach_r0_addr");
      runCycles(3);
      af_full_k = 0;
      runCycles(6);

      $display("[TB] r1 withdraws its request");
      en[0] = 0;
      en[1] = 1;
      queueTxn(0, 1);
      queueTxn(1, 1);
      af_full_k = 1;
      runUntil(1, 0, "reach_r1_addr");
      en[1] = 0;
      en[0] = 1;
      af_full_k = 0;
      runCycles(6);
      en[1] = 1;
      runCycles(8);

      $display("[TB] reset in the middle of a burst");
      queueTxn(0, 2);
      queueTxn(1, 2);
      runUntil(-1, 1, "reach_data_before_rst");
      rst_k = 1;
      stepCycle();
      rst_k = 0;
      runCycles(12);

      $display("[TB] random traffic");
      for (int i = 0; i < 600; i++) begin
         for (int r = 0; r < 2; r++) begin
            en[r] = ($urandom_range(0, 9) != 0);
            if (tot[r] - cur[r] < 3) queueTxn(r, 4);
         end
         af_full_k  = ($urandom_range(0, 3) == 0);
         wdf_full_k = ($urandom_range(0, 3) == 0);
         rst_k      = ($urandom_range(0, 199) == 0);
         stepCycle();
      end
      rst_k = 0;
      af_full_k = 0;
      wdf_full_k = 0;
      runCycles(10);

      $display("test done: total=%0d bad=%0d", check_count, fail_count);
      $finish;
   end

endmodule
